// File: rtl/fmap_stream_tx_if.sv
// Bundle of the upstream load/result signals and the classifier-facing pixel
// stream for fmap_stream_tx; the slave modport is the transmitter itself.
interface fmap_stream_tx_if #(
   parameter int DATA_W = 16,
   parameter int NUM_CH = 4
);
   logic                               wr_en;
   logic [DATA_W-1:0]                  wr_data;
   logic                               load_full;
   logic                               start;
   logic                               busy;
   logic [0:NUM_CH-1][DATA_W-1:0]      pixel_out;
   logic                               valid_out;
   logic                               cls_done;
   logic [3:0]                         cls_result;
   logic [3:0]                         result;
   logic                               result_valid;
   logic                               timeout_err;

   modport master (
      output wr_en, wr_data, start, cls_done, cls_result,
      input  load_full, busy, pixel_out, valid_out, result, result_valid, timeout_err
   );

   modport slave (
      input  wr_en, wr_data, start, cls_done, cls_result,
      output load_full, busy, pixel_out, valid_out, result, result_valid, timeout_err
   );
endinterface

// File: rtl/fmap_stream_tx.sv
// Buffers a planar feature map, streams it to the classifier NUM_CH channels
// per cycle, then waits (with a timeout) for the class index to report back.
module fmap_stream_tx #(
   parameter int DATA_W  = 16,
   parameter int NUM_CH  = 4,
   parameter int CH_SIZE = 49,
   parameter int TIMEOUT = 1000
) (
   input logic             clk,
   input logic             reset,
   fmap_stream_tx_if.slave bus
);

   localparam int DEPTH  = NUM_CH * CH_SIZE;
   localparam int PTR_W  = $clog2(DEPTH + 1);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int IDX_W  = $clog2(CH_SIZE);
   localparam int TMO_W  = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_LOAD,
      S_READY,
      S_STREAM,
      S_WAIT
   } state_t;

   state_t                         r_state;
   state_t                         w_nextState;
   logic [DATA_W-1:0]              r_buf [0:DEPTH-1];
   logic [PTR_W-1:0]               r_wrPtr;
   logic [IDX_W-1:0]               r_rdIdx;
   logic [TMO_W-1:0]               r_tmoCnt;
   logic                           r_valid;
   logic [0:NUM_CH-1][DATA_W-1:0]  r_pixel;
   logic [3:0]                     r_result;
   logic                           r_resultValid;
   logic                           r_timeoutErr;

   logic                           w_write;
   logic                           w_startAccept;
   logic                           w_streamEnd;
   logic                           w_timeoutHit;
   logic                           w_doneAccept;
   logic                           w_loadPixel;
   logic [IDX_W-1:0]               w_nextIdx;

   assign w_write       = (r_state == S_LOAD) && bus.wr_en;
   assign w_doneAccept  = (r_state == S_WAIT) && bus.cls_done;
   assign w_startAccept = (r_state == S_READY) && bus.start;
   assign w_streamEnd   = (r_state == S_STREAM) && (r_rdIdx == IDX_W'(CH_SIZE - 1));
   assign w_timeoutHit  = (r_state == S_WAIT) && !bus.cls_done &&
                          (r_tmoCnt == TMO_W'(TIMEOUT - 1));
   assign w_loadPixel   = w_startAccept || ((r_state == S_STREAM) && !w_streamEnd);
   assign w_nextIdx     = (r_state == S_READY) ? '0 : r_rdIdx + IDX_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_LOAD:   if (w_write && (r_wrPtr == PTR_W'(DEPTH - 1))) w_nextState = S_READY;
         S_READY:  if (bus.start) w_nextState = S_STREAM;
         S_STREAM: if (w_streamEnd) w_nextState = S_WAIT;
         S_WAIT:   if (bus.cls_done || w_timeoutHit) w_nextState = S_LOAD;
         default:  w_nextState = S_LOAD;
      endcase
   end

   // Buffer contents need no reset; stale words are always overwritten before READY.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_buf[r_wrPtr[ADDR_W-1:0]] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr       <= '0;
         r_rdIdx       <= '0;
         r_tmoCnt      <= '0;
         r_valid       <= 1'b0;
         r_pixel       <= '0;
         r_result      <= '0;
         r_resultValid <= 1'b0;
         r_timeoutErr  <= 1'b0;
      end else begin
         r_timeoutErr <= w_timeoutHit;

         if (w_write) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end else if ((r_state == S_WAIT) && (w_nextState == S_LOAD)) begin
            r_wrPtr <= '0;
         end

         r_tmoCnt <= (r_state == S_WAIT) ? r_tmoCnt + TMO_W'(1) : '0;

         if (w_startAccept) begin
            r_resultValid <= 1'b0;
         end else if (w_doneAccept) begin
            r_result      <= bus.cls_result;
            r_resultValid <= 1'b1;
         end

         // Pixel k of every channel is fetched one cycle ahead so the outputs are registered.
         if (w_loadPixel) begin
            r_valid <= 1'b1;
            r_rdIdx <= w_nextIdx;
            for (int c = 0; c < NUM_CH; c++) begin
               r_pixel[c] <= r_buf[ADDR_W'(c * CH_SIZE) + ADDR_W'(w_nextIdx)];
            end
         end else begin
            r_valid <= 1'b0;
            r_pixel <= '0;
         end
      end
   end

   assign bus.load_full    = (r_state == S_READY);
   assign bus.busy         = (r_state == S_STREAM) || (r_state == S_WAIT);
   assign bus.valid_out    = r_valid;
   assign bus.pixel_out    = r_pixel;
   assign bus.result       = r_result;
   assign bus.result_valid = r_resultValid;
   assign bus.timeout_err  = r_timeoutErr;

endmodule
